// File: rtl/help_pkg.sv
// Shared definitions for the help-text scroller: glyph constants, FSM encoding
// and the message table with its lookup helpers.
package help_pkg;

    localparam int TABLE_LEN = 8;
    localparam int GW        = 5;

    typedef logic [GW-1:0] glyph_t;

    localparam glyph_t GLYPH_BLANK = 5'd31;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        STATIC = 2'd1,
        SCROLL = 2'd2
    } fsm_t;

    localparam logic [3:0] LEN_TABLE [16] = '{
        4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd8,
        4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0
    };

    // Glyph 0 of each message sits in the most-significant field; rows are padded with blanks.
    localparam logic [TABLE_LEN*GW-1:0] MSG_GLYPHS [16] = '{
        40'd0, 40'd0, 40'd0, 40'd0, 40'd0, 40'd0,
        {5'd16, 5'd14, 5'd18, 5'd20, 5'd31, 5'd31, 5'd31, 5'd31},
        {5'd16, 5'd14, 5'd18, 5'd20, 5'd31, 5'd12, 5'd18, 5'd10},
        {5'd31, 5'd12, 5'd18, 5'd10, 5'd31, 5'd31, 5'd31, 5'd31},
        {5'd31, 5'd10, 5'd0,  5'd0,  5'd31, 5'd31, 5'd31, 5'd31},
        {5'd31, 5'd5,  5'd24, 5'd11, 5'd31, 5'd31, 5'd31, 5'd31},
        {5'd31, 5'd0,  5'd0,  5'd23, 5'd31, 5'd31, 5'd31, 5'd31},
        {5'd31, 5'd0,  5'd30, 5'd24, 5'd31, 5'd31, 5'd31, 5'd31},
        {5'd23, 5'd14, 5'd5,  5'd23, 5'd31, 5'd31, 5'd31, 5'd31},
        40'd0, 40'd0
    };

    function automatic logic [3:0] msg_len(input logic [3:0] code);
        return LEN_TABLE[code];
    endfunction

    // Any index at or past the message length reads as a blank separator.
    function automatic glyph_t msg_glyph(input logic [3:0] code, input int idx);
        logic [TABLE_LEN*GW-1:0] row;
        row = MSG_GLYPHS[code];
        if (idx < 0 || idx >= int'(LEN_TABLE[code])) return GLYPH_BLANK;
        return row[(TABLE_LEN-1-idx)*GW +: GW];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scroll-rate divider: pulses tick once every SCROLL_DIV enabled cycles.
// clr restarts the count and suppresses the tick on the same cycle.
module tick_gen #(
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = $clog2(SCROLL_DIV);
    localparam logic [CW-1:0]  LAST = CW'(SCROLL_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/help_scroller.sv
// Help-text display driver: looks up the message for the UI state and shows a
// DIGITS-wide window, static when it fits and scrolling with wrap otherwise.
module help_scroller
    import help_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int GLYPH_W    = 5,
    parameter int MSG_LEN    = 8,
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                state,
    input  logic                      en,
    output logic [DIGITS*GLYPH_W-1:0] out,
    output logic                      scrolling,
    output logic                      wrap,
    output logic [1:0]                fsm_state
);

    // Wide enough for p + digit index before the single modulo subtraction.
    localparam int IDX_W = $clog2(MSG_LEN + DIGITS + 1);

    logic [3:0]                state_q;
    logic [3:0]                state_prev;
    logic [3:0]                cur_len;
    fsm_t                      fsm_q;
    fsm_t                      fsm_next;
    logic [IDX_W-1:0]          p_q;
    logic [IDX_W-1:0]          p_next;
    logic [IDX_W-1:0]          seq_len;
    logic [IDX_W-1:0]          idx;
    logic [DIGITS*GLYPH_W-1:0] out_next;
    glyph_t                    glyph;
    logic                      change;
    logic                      tick;
    logic                      step;
    logic                      last;
    logic                      wrap_next;

    assign cur_len = msg_len(state_q);
    assign change  = (state_q != state_prev);
    assign seq_len = IDX_W'(cur_len) + 1'b1;

    tick_gen #(
        .SCROLL_DIV (SCROLL_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (change),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= '0;
            state_prev <= '0;
        end else begin
            state_q    <= state;
            state_prev <= state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= BLANK;
        else        fsm_q <= fsm_next;
    end

    // Mode follows the current message length, so a new message re-enters directly.
    always_comb begin
        fsm_next = BLANK;
        if (cur_len == 4'd0)                fsm_next = BLANK;
        else if (int'(cur_len) <= DIGITS)   fsm_next = STATIC;
        else                                fsm_next = SCROLL;
    end

    always_comb begin
        step      = tick && (fsm_q == SCROLL) && !change;
        last      = (p_q == IDX_W'(cur_len));
        wrap_next = step && last;
        p_next    = p_q;
        if (change)     p_next = '0;
        else if (step)  p_next = last ? '0 : p_q + 1'b1;
        scrolling = (fsm_q == SCROLL);
        idx       = '0;
        glyph     = '0;
        out_next  = '0;
        if (fsm_next != BLANK) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (fsm_next == SCROLL) begin
                    idx = p_next + IDX_W'(i);
                    if (idx >= seq_len) idx = idx - seq_len;
                end else begin
                    idx = IDX_W'(i);
                end
                glyph = msg_glyph(state_q, int'(idx));
                out_next[(DIGITS-1-i)*GLYPH_W +: GLYPH_W] = GLYPH_W'(glyph);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            p_q  <= p_next;
            out  <= out_next;
            wrap <= wrap_next;
        end
    end

    assign fsm_state = fsm_q;

endmodule

// File: doc/help_scroller.md
# help_scroller

Parametrised help-text display driver for the calculator front end. Maps the 4-bit UI state to a stored message of up to `MSG_LEN` glyphs and presents a `DIGITS`-wide window of it on the segment display. Messages that fit are shown static; longer ones scroll left one glyph per tick and wrap. Sits between the top-level UI FSM and the display glyph decoder, replacing the fixed four-glyph combinational help lookup.

## Interface

Parameters:
- `DIGITS`, 4: number of display digits (window width, ≥1).
- `GLYPH_W`, 5: bits per glyph code.
- `MSG_LEN`, 8: maximum glyphs per message (≥`DIGITS`).
- `SCROLL_DIV`, 25_000_000: clk cycles per scroll step (≥2).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `state` in 4: UI state code selecting the message.
- `en` in 1: 1 = run; 0 = freeze the scroll position and divider, hold the output.
- `out` out `DIGITS*GLYPH_W`: window glyphs; digit 0 (leftmost) occupies the most-significant field.
- `scrolling` out 1: current message length > `DIGITS`.
- `wrap` out 1: one-cycle pulse when the scroll position returns to 0.

## Operation

- Message table (package constant), indexed by state: length `len` (0..`MSG_LEN`) plus glyphs.
  - 6: len 4 {16,14,18,20}.
  - 7: len 8 {16,14,18,20,31,12,18,10}.
  - 8: {31,12,18,10}.
  - 9: {31,10,0,0}.
  - 10: {31,5,24,11}.
  - 11: {31,0,0,23}.
  - 12: {31,0,30,24}.
  - 13: {23,14,5,23}.
  - All other codes: len 0.
- FSM states:
  - BLANK: len = 0. `out` = all zeros.
  - STATIC: 0 < len ≤ `DIGITS`. Glyphs are left-aligned; unused right digits carry `GLYPH_BLANK` (31). Position stays 0.
  - SCROLL: len > `DIGITS`.
- Scroll sequence:
  - Sequence S = message followed by one `GLYPH_BLANK` separator, so L = len+1.
  - Digit i shows S[(p+i) mod L]. Position p is 0..L-1.
  - On each tick p increments; L-1 → 0 wraps and asserts `wrap`.
  - Modulo is computed without a divider: compare p+i against L and subtract L once.
- Message change:
  - `state` is registered internally.
  - When the registered value differs from the previous one: FSM re-enters per the new len, p = 0, divider = 0, no `wrap` pulse.
- `en` = 0:
  - Divider and p hold. `out` still follows message changes (reload to p = 0).
  - A tick cannot occur while `en` = 0.
- Simultaneous state change and tick: the state change wins. p = 0, no `wrap`.

## Timing

- Reset (asynchronous assert; synchronous-safe release): `out` = 0, `scrolling` = 0, `wrap` = 0, p = 0, divider = 0, FSM = BLANK, registered state = 0.
- Latency: `state` change → new `out` and `scrolling` = 2 clk (input register + output register).
- Tick: divider counts 0..`SCROLL_DIV`-1 while `en` = 1. The tick fires on the cycle the count equals `SCROLL_DIV`-1, and the count returns to 0 on that same cycle.
- `out` updates 1 clk after the tick.
- `wrap` is asserted on the same cycle `out` shows p = 0 after a wrap, and for that cycle only.
- In STATIC and BLANK states the divider runs but ticks are ignored, and `wrap` is never asserted.
- Reset mid-scroll: immediate return to the reset values. After release, the message is reloaded 2 clk after the first sampled `state`.

## Structure

- Package `help_pkg` holds:
  - `GLYPH_BLANK` = 31.
  - FSM state enum (BLANK/STATIC/SCROLL).
  - Message table as constant arrays (lengths, glyphs padded to `MSG_LEN`).
  - Lookup function `msg_len(state)`, `msg_glyph(state, idx)`.
- Sub-module `tick_gen`: parametrised by `SCROLL_DIV`. Inputs `clk`, `rst_n`, `en`, `clr`; output `tick`.

## Test plan

All tests use `SCROLL_DIV` = 4 and defaults otherwise.

- Reset then `state` = 6 → after 2 clk, `out` = {16,14,18,20}, `scrolling` = 0. Held for 40 clk with no `wrap`.
- `state` = 9 → `out` = {31,10,0,0}. `state` = 3 → `out` = 0, `scrolling` = 0.
- `state` = 7 → window at p = 0 is {16,14,18,20}. Every 4 clk p advances: p = 1 gives {14,18,20,31}; p = 4 gives {31,12,18,10}; p = 8 gives {31,16,14,18}. The next tick returns to {16,14,18,20} with a one-cycle `wrap`.
- Scrolling `state` = 7 at p = 3, then `en` = 0 for 20 clk → `out` is frozen. `en` = 1 → the next step arrives exactly 4 clk later, to p = 4.
- `state` changes 7 → 13 on the tick cycle → `out` = {23,14,5,23} at p = 0, with no `wrap`.
- `rst_n` pulsed low mid-scroll → `out` = 0 asynchronously. After release with `state` = 7, scrolling restarts from p = 0.
